fp_cvt_f_i_seq: RTL

FP_CVT_F_I_SEQ -- requirements
Module: fp_cvt_f_i_seq

---
 rtl/fp_cvt_f_i_seq_if.sv | 21 ++
 rtl/fp_cvt_f_i_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fp_cvt_f_i_seq_if.sv
// Request/response bundle for the float-to-integer converter.
interface fp_cvt_f_i_seq_if;
   logic        start;
   logic        s_u;
   logic [2:0]  rm;
   logic [31:0] in_data;
   logic        busy;
   logic        done;
   logic [31:0] out_data;
   logic [4:0]  fflags;

   modport master (
      output start, s_u, rm, in_data,
      input  busy, done, out_data, fflags
   );

   modport slave (
      input  start, s_u, rm, in_data,
      output busy, done, out_data, fflags
   );
endinterface

// File: rtl/fp_cvt_f_i_seq.sv
// Multi-cycle fcvt.w.s / fcvt.wu.s converter (IDLE->ALIGN->ROUND->DONE).
// Define FP_CVT_FFLAGS_EN to compute fflags; otherwise fflags is tied to 0.
module fp_cvt_f_i_seq (
   input logic              clk,
   input logic              rst,
   fp_cvt_f_i_seq_if.slave  cvt
);
   typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

   state_t state_q, state_d;

   logic [31:0] op_q;
   logic        s_u_q;
   logic [2:0]  rm_q;
   logic        sign_q;
   logic        nan_q;
   logic        big_q;
   logic        g_q;
   logic        st_q;
   logic [31:0] int_q;
   logic [31:0] out_q;

   logic [7:0]  a_exp;
   logic [23:0] a_mant;
   logic [63:0] a_ext;
   logic [63:0] a_sh;
   logic        a_nan;
   logic        a_big;
   logic        a_tiny;

   logic        r_inc;
   logic [32:0] r_mag;
   logic        r_sat;
   logic [31:0] r_data;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cvt.start) state_d = ALIGN;
         ALIGN:   state_d = ROUND;
         ROUND:   state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Integer part lands in a_sh[63:32], guard at [31], sticky below.
   always_comb begin
      a_exp  = op_q[30:23];
      a_mant = {a_exp != 8'd0, op_q[22:0]};
      a_ext  = {8'd0, a_mant, 32'd0};
      a_sh   = 64'd0;
      a_nan  = (a_exp == 8'hFF) && (op_q[22:0] != 23'd0);
      a_big  = a_exp >= 8'd159;
      a_tiny = (a_exp < 8'd126) && (op_q[30:0] != 31'd0);
      if (a_big)
         a_sh = 64'd0;
      else if (a_exp >= 8'd150)
         a_sh = a_ext << (a_exp - 8'd150);
      else if (a_exp >= 8'd126)
         a_sh = a_ext >> (8'd150 - a_exp);
   end

   always_comb begin
      r_inc = 1'b0;
      unique case (rm_q)
         3'b001:  r_inc = 1'b0;
         3'b010:  r_inc = sign_q & (g_q | st_q);
         3'b011:  r_inc = ~sign_q & (g_q | st_q);
         3'b100:  r_inc = g_q;
         default: r_inc = g_q & (st_q | int_q[0]);
      endcase
      r_mag = {1'b0, int_q} + {32'd0, r_inc};
      r_sat = 1'b0;
      if (nan_q || big_q)
         r_sat = 1'b1;
      else if (s_u_q)
         r_sat = sign_q ? (r_mag != 33'd0) : r_mag[32];
      else
         r_sat = sign_q ? (r_mag > 33'h080000000)
                        : (r_mag > 33'h07FFFFFFF);
      if (r_sat) begin
         if (nan_q || !sign_q)
            r_data = s_u_q ? 32'hFFFFFFFF : 32'h7FFFFFFF;
         else
            r_data = s_u_q ? 32'h00000000 : 32'h80000000;
      end else begin
         r_data = sign_q ? (32'd0 - r_mag[31:0]) : r_mag[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         s_u_q  <= 1'b0;
         rm_q   <= '0;
         sign_q <= 1'b0;
         nan_q  <= 1'b0;
         big_q  <= 1'b0;
         g_q    <= 1'b0;
         st_q   <= 1'b0;
         int_q  <= '0;
         out_q  <= '0;
      end else begin
         if (state_q == IDLE && cvt.start) begin
            op_q  <= cvt.in_data;
            s_u_q <= cvt.s_u;
            rm_q  <= cvt.rm;
         end
         if (state_q == ALIGN) begin
            sign_q <= op_q[31];
            nan_q  <= a_nan;
            big_q  <= a_big;
            int_q  <= a_sh[63:32];
            g_q    <= a_sh[31];
            st_q   <= (|a_sh[30:0]) | a_tiny;
         end
         if (state_q == ROUND) out_q <= r_data;
      end
   end

`ifdef FP_CVT_FFLAGS_EN
   logic [4:0] flags_q;

   always_ff @(posedge clk) begin
      if (rst)
         flags_q <= '0;
      else if (state_q == ROUND)
         flags_q <= {r_sat, 3'b000, ~r_sat & (g_q | st_q)};
   end

   assign cvt.fflags = flags_q;
`else
   assign cvt.fflags = 5'b00000;
`endif

   assign cvt.busy     = state_q != IDLE;
   assign cvt.done     = state_q == DONE;
   assign cvt.out_data = out_q;
endmodule
